// File: rtl/icache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package icache_pkg;

  localparam int ICACHE_INDEX_BITS  = 6;
  localparam int ICACHE_OFFSET_BITS = 2;

  typedef logic [31:0] word_t;

  typedef enum logic {
    ICACHE_IDLE,
    ICACHE_REFILL
  } icache_state_e;

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache, bundled as one interface.
interface icache_if
  import icache_pkg::*;
;
  word_t pc_to_ic;
  logic  inst_valid;
  word_t inst_from_ic;
  logic  mem_req;
  word_t mem_addr;
  logic  mem_valid;
  word_t mem_data;

  modport master (
    output pc_to_ic, mem_valid, mem_data,
    input  inst_valid, inst_from_ic, mem_req, mem_addr
  );

  modport slave (
    input  pc_to_ic, mem_valid, mem_data,
    output inst_valid, inst_from_ic, mem_req, mem_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with word-by-word line refill.
// Define ICACHE_PERF_EN to add the hit_cnt/miss_cnt performance counters.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS  = ICACHE_INDEX_BITS,
  parameter int OFFSET_BITS = ICACHE_OFFSET_BITS
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  icache_if.slave   bus
`ifdef ICACHE_PERF_EN
  ,
  output word_t     hit_cnt,
  output word_t     miss_cnt
`endif
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << OFFSET_BITS;
  localparam int LINE_W   = INDEX_BITS + OFFSET_BITS;
  localparam int TAG_BITS = 30 - LINE_W;

  logic [OFFSET_BITS-1:0] pc_off;
  logic [INDEX_BITS-1:0]  pc_idx;
  logic [TAG_BITS-1:0]    pc_tag;
  logic                   unused_pc_lsbs;

  assign pc_off         = bus.pc_to_ic[OFFSET_BITS+1:2];
  assign pc_idx         = bus.pc_to_ic[LINE_W+1:OFFSET_BITS+2];
  assign pc_tag         = bus.pc_to_ic[31:LINE_W+2];
  assign unused_pc_lsbs = ^bus.pc_to_ic[1:0];

  logic                line_valid [LINES];
  logic [TAG_BITS-1:0] line_tag   [LINES];
  word_t               line_data  [LINES*WORDS];

  icache_state_e          state_q, state_d;
  logic [TAG_BITS-1:0]    ref_tag;
  logic [INDEX_BITS-1:0]  ref_idx;
  logic [OFFSET_BITS-1:0] cnt_q, cnt_nxt;
  logic                   mem_req_q;
  word_t                  mem_addr_q;
  logic                   hit, start_refill, accept_word, last_word;

  assign hit              = line_valid[pc_idx] && (line_tag[pc_idx] == pc_tag);
  assign bus.inst_valid   = hit;
  assign bus.inst_from_ic = line_data[{pc_idx, pc_off}];
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_addr     = mem_addr_q;
  assign cnt_nxt          = cnt_q + OFFSET_BITS'(1);

  always_ff @(posedge clk) begin
    if (!rst)     state_q <= ICACHE_IDLE;
    else if (rdy) state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    start_refill = 1'b0;
    accept_word  = 1'b0;
    last_word    = &cnt_q;
    case (state_q)
      ICACHE_IDLE: begin
        if (!hit) begin
          start_refill = 1'b1;
          state_d      = ICACHE_REFILL;
        end
      end
      ICACHE_REFILL: begin
        if (bus.mem_valid) begin
          accept_word = 1'b1;
          if (last_word) state_d = ICACHE_IDLE;
        end
      end
      default: state_d = ICACHE_IDLE;
    endcase
  end

  // Valid bits stay clear until the last word lands, so partial lines never hit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      cnt_q      <= '0;
      ref_tag    <= '0;
      ref_idx    <= '0;
      for (int i = 0; i < LINES; i++) line_valid[i] <= 1'b0;
    end else if (rdy) begin
      if (start_refill) begin
        ref_tag             <= pc_tag;
        ref_idx             <= pc_idx;
        line_valid[pc_idx]  <= 1'b0;
        cnt_q               <= '0;
        mem_req_q           <= 1'b1;
        mem_addr_q          <= {pc_tag, pc_idx, {OFFSET_BITS{1'b0}}, 2'b00};
      end else if (accept_word) begin
        if (last_word) begin
          line_valid[ref_idx] <= 1'b1;
          mem_req_q           <= 1'b0;
        end else begin
          cnt_q      <= cnt_nxt;
          mem_addr_q <= {ref_tag, ref_idx, cnt_nxt, 2'b00};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && rdy && accept_word) begin
      line_data[{ref_idx, cnt_q}] <= bus.mem_data;
      if (last_word) line_tag[ref_idx] <= ref_tag;
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (rdy) begin
      if (hit)          hit_cnt  <= hit_cnt + 32'd1;
      if (start_refill) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a memory responder checks requested addresses against a scoreboard queue.
module tb_icache;
  import icache_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  icache_if bus();
`ifdef ICACHE_PERF_EN
  word_t hit_cnt, miss_cnt;
`endif

  icache dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .bus      (bus)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  word_t exp_q[$];

  function automatic word_t memval(input word_t a);
    int w;
    w = int'(a[3:2]);
    return {a[31:4], 4'h0} ^ (32'h11 * word_t'(w + 1));
  endfunction

  task automatic check(input string tag, input word_t got, input word_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_line(input word_t base);
    for (int w = 0; w < 4; w++) exp_q.push_back({base[31:4], 4'h0} + word_t'(4 * w));
  endtask

  // Called at a negedge while a word is being requested; returns at the negedge after the accept.
  task automatic feed_word();
    word_t a;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: got request %h expected none", bus.mem_addr);
      a = bus.mem_addr;
    end else begin
      a = exp_q.pop_front();
    end
    check("mem_req_refill", word_t'(bus.mem_req), 32'd1);
    check("mem_addr", bus.mem_addr, a);
    bus.mem_valid = 1'b1;
    bus.mem_data  = memval(a);
    @(negedge clk);
    bus.mem_valid = 1'b0;
    bus.mem_data  = '0;
  endtask

  task automatic probe(input string tag, input word_t pc, input logic exp_v, input word_t exp_d);
    bus.pc_to_ic = pc;
    #1;
    check({tag, "_valid"}, word_t'(bus.inst_valid), word_t'(exp_v));
    if (exp_v) check({tag, "_data"}, bus.inst_from_ic, exp_d);
  endtask

  initial begin
    rst           = 1'b0;
    rdy           = 1'b1;
    bus.pc_to_ic  = 32'h0;
    bus.mem_valid = 1'b0;
    bus.mem_data  = '0;
    repeat (3) @(negedge clk);
    check("reset_inst_valid", word_t'(bus.inst_valid), 32'd0);
    check("reset_mem_req", word_t'(bus.mem_req), 32'd0);
    check("reset_mem_addr", bus.mem_addr, 32'd0);
`ifdef ICACHE_PERF_EN
    check("reset_hit_cnt", hit_cnt, 32'd0);
    check("reset_miss_cnt", miss_cnt, 32'd0);
`endif

    // Cold miss on line 0, refill with back-to-back words.
    rst = 1'b1;
    probe("cold_miss", 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    expect_line(32'h0);
    for (int i = 0; i < 4; i++) feed_word();
    check("after_fill_req", word_t'(bus.mem_req), 32'd0);
    probe("fill0_w0", 32'h0, 1'b1, 32'h11);
    probe("fill0_w2", 32'h8, 1'b1, 32'h33);
    @(negedge clk);
    check("hit_no_req", word_t'(bus.mem_req), 32'd0);

    // Stray mem_valid in IDLE must not disturb the line.
    bus.mem_valid = 1'b1;
    bus.mem_data  = 32'hdead_beef;
    @(negedge clk);
    bus.mem_valid = 1'b0;
    probe("idle_pulse_w2", 32'h8, 1'b1, 32'h33);
    check("idle_pulse_req", word_t'(bus.mem_req), 32'd0);

    // Conflict at index 0, with a one-cycle gap between words.
    probe("conflict_miss", 32'h400, 1'b0, 32'h0);
    @(negedge clk);
    expect_line(32'h400);
    for (int i = 0; i < 4; i++) begin
      feed_word();
      if (i < 3) begin
        check("gap_hold_addr", bus.mem_addr, 32'h400 + word_t'(4 * (i + 1)));
        @(negedge clk);
      end
    end
    probe("conflict_w0", 32'h400, 1'b1, memval(32'h400));
    probe("evicted", 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    expect_line(32'h0);
    for (int i = 0; i < 4; i++) feed_word();
    probe("refetch_w3", 32'hC, 1'b1, 32'h44);

    // Jump from 0x10 to 0x20 after the second word.
    bus.pc_to_ic = 32'h10;
    @(negedge clk);
    expect_line(32'h10);
    feed_word();
    feed_word();
    bus.pc_to_ic = 32'h20;
    feed_word();
    feed_word();
    #1;
    check("jump_idle_req", word_t'(bus.mem_req), 32'd0);
    check("jump_new_miss", word_t'(bus.inst_valid), 32'd0);
    @(negedge clk);
    expect_line(32'h20);
    for (int i = 0; i < 4; i++) feed_word();
    probe("jump_new_w3", 32'h2C, 1'b1, memval(32'h2C));
    probe("jump_old_w1", 32'h14, 1'b1, memval(32'h14));

    // rdy low for five cycles mid-refill, with an ignored pulse.
    bus.pc_to_ic = 32'h40;
    @(negedge clk);
    expect_line(32'h40);
    feed_word();
    probe("partial_no_hit", 32'h40, 1'b0, 32'h0);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.mem_valid = (i == 2);
      bus.mem_data  = 32'hbad0_0000;
      @(negedge clk);
      bus.mem_valid = 1'b0;
      check("frozen_addr", bus.mem_addr, 32'h44);
      check("frozen_req", word_t'(bus.mem_req), 32'd1);
    end
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) feed_word();
    probe("resume_w1", 32'h44, 1'b1, memval(32'h44));
    probe("resume_w3", 32'h4C, 1'b1, memval(32'h4C));

    // Reset in the middle of a refill discards the line.
    bus.pc_to_ic = 32'h80;
    @(negedge clk);
    expect_line(32'h80);
    feed_word();
    feed_word();
`ifdef ICACHE_PERF_EN
    check("miss_cnt_total", miss_cnt, 32'd7);
`endif
    rst = 1'b0;
    @(negedge clk);
    exp_q.delete();
    check("midreset_req", word_t'(bus.mem_req), 32'd0);
    check("midreset_addr", bus.mem_addr, 32'd0);
`ifdef ICACHE_PERF_EN
    check("midreset_hit_cnt", hit_cnt, 32'd0);
    check("midreset_miss_cnt", miss_cnt, 32'd0);
`endif
    probe("midreset_line_gone", 32'h80, 1'b0, 32'h0);
    probe("midreset_old_gone", 32'h0, 1'b0, 32'h0);
    rst = 1'b1;
    probe("post_reset_miss", 32'h80, 1'b0, 32'h0);
    @(negedge clk);
    check("post_reset_req", word_t'(bus.mem_req), 32'd1);
    check("post_reset_addr", bus.mem_addr, 32'h80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
